uart_io_port: RTL and testbench

- IO-bus responder for the processor's UART ports, sitting on the other end of the processor's IO_port_ID / IO_write_data / IO_read_data / strobe interface.
- Port 01h is the data port:
  - A write to port 01h queues a byte in the TX FIFO, which is serialized as 8N1 on uart_txd.
  - A read from port 01h pops the RX FIFO, which is filled by an 8N1 deserializer on uart_rxd.
- Ports 02h, 03h and 04h return RX-present, TX-full and sticky error status.
- Replaces the bench's behavioural IO model in synthesis and board builds.

---
 rtl/uart_io_port.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_io_port.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_port.sv
// uart_io_port: IO-bus responder for the processor's UART ports.
//   Port 01h write : queue a byte into the TX FIFO (8N1 serializer on uart_txd)
//   Port 01h read  : pop the RX FIFO (8N1 deserializer on uart_rxd)
//   Port 02h read  : FFh when RX data is present
//   Port 03h read  : FFh when the TX FIFO is full
//   Port 04h read  : {5'b0, framing, rx_overrun, tx_overflow}; write clears
//
// Ports:
//   clk100          system clock, rising edge
//   reset           synchronous, active-low
//   IO_port_ID      port address from the processor
//   IO_write_data   write data from the processor
//   IO_write_strobe write strobe (one access per rising edge of the strobe)
//   IO_read_strobe  read strobe (one access per rising edge of the strobe)
//   IO_read_data    combinational read data, 00h while the strobe is low
//   uart_rxd        asynchronous serial input, idles high
//   uart_txd        serial output, idles high
module uart_io_port #(
    parameter int unsigned CLKS_PER_BIT  = 868,
    parameter int unsigned TX_FIFO_DEPTH = 4,
    parameter int unsigned RX_FIFO_DEPTH = 4
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic [7:0] IO_port_ID,
    input  logic [7:0] IO_write_data,
    input  logic       IO_write_strobe,
    input  logic       IO_read_strobe,
    output logic [7:0] IO_read_data,
    input  logic       uart_rxd,
    output logic       uart_txd
);

    localparam int unsigned TAW = $clog2(TX_FIFO_DEPTH);
    localparam int unsigned RAW = $clog2(RX_FIFO_DEPTH);
    localparam logic [TAW:0] TX_FULL_CNT = (TAW+1)'(TX_FIFO_DEPTH);
    localparam logic [RAW:0] RX_FULL_CNT = (RAW+1)'(RX_FIFO_DEPTH);
    localparam logic [15:0]  BAUD_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]  HALF_LAST   = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- strobe qualification ----------------
    logic wr_q, rd_q, wr_acc, rd_acc;

    always_ff @(posedge clk100) begin
        if (!reset) begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
        end else begin
            wr_q <= IO_write_strobe;
            rd_q <= IO_read_strobe;
        end
    end

    assign wr_acc = IO_write_strobe & ~wr_q;
    assign rd_acc = IO_read_strobe & ~rd_q;

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem [TX_FIFO_DEPTH];
    logic [TAW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TAW:0]   tx_count;
    logic           tx_full, tx_empty, tx_push, tx_pop, tx_ovf;

    assign tx_full  = (tx_count == TX_FULL_CNT);
    assign tx_empty = (tx_count == '0);
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign tx_push  = wr_acc && (IO_port_ID == 8'h01) && (!tx_full || tx_pop);
    assign tx_ovf   = wr_acc && (IO_port_ID == 8'h01) && tx_full && !tx_pop;

    always_ff @(posedge clk100) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= IO_write_data;
    end

    always_ff @(posedge clk100) begin
        if (!reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TAW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TAW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + (TAW+1)'(1);
                2'b01:   tx_count <= tx_count - (TAW+1)'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_baud;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_done, tx_line;

    assign tx_done = (tx_baud == BAUD_LAST);

    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_state_n = TX_START;
                    tx_pop     = 1'b1;
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_done) tx_state_n = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_shift[0];
                if (tx_done && tx_bit == 3'd7) tx_state_n = TX_STOP;
            end
            TX_STOP: begin
                tx_line = 1'b1;
                if (tx_done) begin
                    if (!tx_empty) begin
                        tx_state_n = TX_START;
                        tx_pop     = 1'b1;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // uart_txd is the registered line level, one cycle behind the state.
    always_ff @(posedge clk100) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            uart_txd <= tx_line;
            if (tx_state == TX_IDLE || tx_done) tx_baud <= '0;
            else                                tx_baud <= tx_baud + 16'd1;
            if (tx_pop) begin
                tx_shift <= tx_mem[tx_rd_ptr];
                tx_bit   <= '0;
            end else if (tx_state == TX_DATA && tx_done) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end
    end

    // ---------------- RX synchronizer + FSM ----------------
    logic rx_meta, rx_s;

    always_ff @(posedge clk100) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rx_s    <= rx_meta;
        end
    end

    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_baud;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_armed, rx_sample;
    logic        rx_push, rx_pop, rx_ovr, rx_frm, rx_full, rx_empty;

    always_comb begin
        rx_state_n = rx_state;
        rx_sample  = 1'b0;
        rx_push    = 1'b0;
        rx_ovr     = 1'b0;
        rx_frm     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                // rx_armed keeps a low stop bit from being taken as a new start.
                if (rx_armed && !rx_s) rx_state_n = RX_START;
            end
            RX_START: begin
                rx_sample = (rx_baud == HALF_LAST);
                if (rx_sample) rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                rx_sample = (rx_baud == BAUD_LAST);
                if (rx_sample && rx_bit == 3'd7) rx_state_n = RX_STOP;
            end
            RX_STOP: begin
                rx_sample = (rx_baud == BAUD_LAST);
                if (rx_sample) begin
                    rx_state_n = RX_IDLE;
                    if (!rx_s)                     rx_frm  = 1'b1;
                    else if (!rx_full || rx_pop)   rx_push = 1'b1;
                    else                           rx_ovr  = 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_armed <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            if (rx_state == RX_IDLE || rx_sample) rx_baud <= '0;
            else                                  rx_baud <= rx_baud + 16'd1;
            if (rx_state == RX_START)                  rx_bit <= '0;
            else if (rx_state == RX_DATA && rx_sample) rx_bit <= rx_bit + 3'd1;
            if (rx_state == RX_DATA && rx_sample) rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_state == RX_STOP && rx_sample) rx_armed <= 1'b0;
            else if (rx_s)                        rx_armed <= 1'b1;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]     rx_mem [RX_FIFO_DEPTH];
    logic [RAW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RAW:0]   rx_count;

    assign rx_full  = (rx_count == RX_FULL_CNT);
    assign rx_empty = (rx_count == '0);
    assign rx_pop   = rd_acc && (IO_port_ID == 8'h01) && !rx_empty;

    always_ff @(posedge clk100) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk100) begin
        if (!reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RAW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RAW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + (RAW+1)'(1);
                2'b01:   rx_count <= rx_count - (RAW+1)'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // ---------------- sticky error flags ----------------
    logic [2:0] err;
    logic       err_clr;

    assign err_clr = wr_acc && (IO_port_ID == 8'h04);

    // Bits set in the clearing cycle survive the clear.
    always_ff @(posedge clk100) begin
        if (!reset) err <= '0;
        else        err <= (err_clr ? 3'b000 : err) | {rx_frm, rx_ovr, tx_ovf};
    end

    // ---------------- read data ----------------
    always_comb begin
        IO_read_data = '0;
        if (reset && IO_read_strobe) begin
            case (IO_port_ID)
                8'h01:   IO_read_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
                8'h02:   IO_read_data = rx_empty ? 8'h00 : 8'hFF;
                8'h03:   IO_read_data = tx_full ? 8'hFF : 8'h00;
                8'h04:   IO_read_data = {5'b00000, err};
                default: IO_read_data = 8'hFF;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_io_port.sv
// Self-checking bench for uart_io_port with CLKS_PER_BIT=4 and 4-deep FIFOs.
// A line-level UART receiver decodes uart_txd into frames; RX traffic is
// generated bit by bit and checked against a queue model of the RX FIFO.
module tb_uart_io_port;

    localparam int unsigned BIT   = 4;
    localparam int unsigned DEPTH = 4;

    logic       clk100 = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] IO_port_ID = '0;
    logic [7:0] IO_write_data = '0;
    logic       IO_write_strobe = 1'b0;
    logic       IO_read_strobe = 1'b0;
    logic [7:0] IO_read_data;
    logic       uart_rxd = 1'b1;
    logic       uart_txd;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    always #5 clk100 = ~clk100;
    always @(posedge clk100) cyc <= cyc + 1;

    uart_io_port #(
        .CLKS_PER_BIT (BIT),
        .TX_FIFO_DEPTH(DEPTH),
        .RX_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk100         (clk100),
        .reset          (reset),
        .IO_port_ID     (IO_port_ID),
        .IO_write_data  (IO_write_data),
        .IO_write_strobe(IO_write_strobe),
        .IO_read_strobe (IO_read_strobe),
        .IO_read_data   (IO_read_data),
        .uart_rxd       (uart_rxd),
        .uart_txd       (uart_txd)
    );

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int unsigned t;
    } frame_t;

    frame_t txq[$];

    // Reference receiver: detect a falling edge, then sample mid-bit.
    initial begin : tx_monitor
        logic   prev;
        frame_t f;
        prev = 1'b1;
        forever begin
            @(negedge clk100);
            if (prev === 1'b1 && uart_txd === 1'b0) begin
                f.t = cyc;
                repeat (BIT / 2) @(negedge clk100);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk100);
                    f.data[i] = uart_txd;
                end
                repeat (BIT) @(negedge clk100);
                f.stop = uart_txd;
                txq.push_back(f);
            end
            prev = uart_txd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        @(negedge clk100);
        IO_port_ID      = port;
        IO_write_data   = data;
        IO_write_strobe = 1'b1;
        @(negedge clk100);
        IO_write_strobe = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] port, output logic [7:0] data);
        @(negedge clk100);
        IO_port_ID     = port;
        IO_read_strobe = 1'b1;
        #1 data = IO_read_data;
        @(negedge clk100);
        IO_read_strobe = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [7:0] port, input logic [7:0] exp);
        logic [7:0] d;
        io_read(port, d);
        check(tag, {24'h0, d}, {24'h0, exp});
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk100);
        uart_rxd = 1'b0;
        repeat (BIT) @(negedge clk100);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (BIT) @(negedge clk100);
        end
        uart_rxd = stop;
        repeat (BIT) @(negedge clk100);
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk100);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (txq.size() < n && k < budget) begin
            @(negedge clk100);
            k++;
        end
        check("tx_frame_count", txq.size(), n);
    endtask

    initial begin : main
        logic [7:0]  rd;
        logic [7:0]  b;
        logic [7:0]  bytes [5];
        logic [7:0]  rxm[$];
        logic [2:0]  err_m;
        logic        lvl;
        int unsigned p;
        int unsigned idx;

        // ---- reset state ----
        reset = 1'b0;
        repeat (3) @(negedge clk100);
        check("rst_txd", {31'h0, uart_txd}, 1);
        IO_port_ID     = 8'hFF;
        IO_read_strobe = 1'b1;
        #1 check("rst_rdata", {24'h0, IO_read_data}, 0);
        IO_read_strobe = 1'b0;
        @(negedge clk100);
        reset = 1'b1;
        repeat (2) @(negedge clk100);
        err_m = '0;

        check_read("idle_rx_present", 8'h02, 8'h00);
        check_read("idle_tx_full", 8'h03, 8'h00);
        check_read("idle_err", 8'h04, 8'h00);
        check_read("idle_rx_data", 8'h01, 8'h00);
        check_read("port_00", 8'h00, 8'hFF);
        p = $urandom_range(255, 5);
        check_read("port_other", p[7:0], 8'hFF);

        // ---- single frame, line checked every cycle ----
        b = 8'hA5;
        io_write(8'h01, b);
        @(negedge clk100);
        check("tx_latency", {31'h0, uart_txd}, 1);
        for (int k = 0; k < 10 * BIT; k++) begin
            @(negedge clk100);
            idx = k / BIT;
            if (idx == 0)      lvl = 1'b0;
            else if (idx <= 8) lvl = b[idx - 1];
            else               lvl = 1'b1;
            check("tx_a5_line", {31'h0, uart_txd}, {31'h0, lvl});
        end
        repeat (BIT) @(negedge clk100);
        check("tx_idle_after", {31'h0, uart_txd}, 1);
        repeat (4) @(negedge clk100);
        txq.delete();

        // ---- fill TX, overflow, back-to-back frames ----
        // The first byte goes straight into the shifter, so DEPTH+1 writes fill the port.
        for (int i = 0; i < 5; i++) begin
            bytes[i] = 8'($urandom);
            io_write(8'h01, bytes[i]);
        end
        check_read("tx_full", 8'h03, 8'hFF);
        @(negedge clk100);
        IO_port_ID = 8'h03;
        #1 check("rdata_strobe_low", {24'h0, IO_read_data}, 0);
        io_write(8'h01, 8'h55);
        err_m[0] = 1'b1;
        check_read("err_tx_overflow", 8'h04, {5'b0, err_m});
        wait_frames(5, 400);
        for (int i = 0; i < 5; i++) begin
            if (i < txq.size()) begin
                check("tx_b2b_data", {24'h0, txq[i].data}, {24'h0, bytes[i]});
                check("tx_b2b_stop", {31'h0, txq[i].stop}, 1);
                if (i > 0) check("tx_b2b_gap", txq[i].t - txq[i-1].t, 10 * BIT);
            end
        end
        repeat (60) @(negedge clk100);
        check("tx_dropped_not_sent", txq.size(), 5);
        check("tx_idle_high", {31'h0, uart_txd}, 1);
        io_write(8'h04, 8'($urandom));
        err_m = '0;
        check_read("err_clear", 8'h04, 8'h00);
        txq.delete();

        // ---- RX single byte and held read strobe ----
        b = 8'($urandom);
        send_rx(b, 1'b1);
        check_read("rx_present", 8'h02, 8'hFF);
        check_read("rx_data", 8'h01, b);
        check_read("rx_empty_after", 8'h02, 8'h00);
        check_read("rx_empty_data", 8'h01, 8'h00);

        bytes[0] = 8'($urandom);
        bytes[1] = 8'($urandom);
        send_rx(bytes[0], 1'b1);
        send_rx(bytes[1], 1'b1);
        @(negedge clk100);
        IO_port_ID     = 8'h01;
        IO_read_strobe = 1'b1;
        #1 rd = IO_read_data;
        repeat (3) @(negedge clk100);
        IO_read_strobe = 1'b0;
        check("rx_hold_data", {24'h0, rd}, {24'h0, bytes[0]});
        check_read("rx_hold_one_pop", 8'h01, bytes[1]);
        check_read("rx_hold_empty", 8'h02, 8'h00);

        // ---- RX overrun ----
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            if (rxm.size() < DEPTH) rxm.push_back(b);
            else                    err_m[1] = 1'b1;
            send_rx(b, 1'b1);
        end
        check_read("err_rx_overrun", 8'h04, {5'b0, err_m});
        while (rxm.size() > 0) check_read("rx_fifo_order", 8'h01, rxm.pop_front());
        check_read("rx_drained", 8'h02, 8'h00);
        io_write(8'h04, 8'h00);
        err_m = '0;

        // ---- framing error and glitch rejection ----
        send_rx(8'($urandom), 1'b0);
        err_m[2] = 1'b1;
        check_read("frm_no_byte", 8'h02, 8'h00);
        check_read("err_framing", 8'h04, {5'b0, err_m});
        io_write(8'h04, 8'h00);
        err_m = '0;
        @(negedge clk100);
        uart_rxd = 1'b0;
        @(negedge clk100);
        uart_rxd = 1'b1;
        repeat (60) @(negedge clk100);
        check_read("glitch_no_byte", 8'h02, 8'h00);
        check_read("glitch_no_err", 8'h04, 8'h00);

        // ---- reset in mid-frame ----
        send_rx(8'($urandom), 1'b1);
        io_write(8'h01, 8'h00);
        for (int i = 0; i < 5; i++) io_write(8'h01, 8'($urandom));
        check_read("pre_rst_tx_full", 8'h03, 8'hFF);
        check_read("pre_rst_rx_present", 8'h02, 8'hFF);
        check_read("pre_rst_err", 8'h04, 8'h01);
        @(negedge clk100);
        uart_rxd = 1'b0;
        repeat (2 * BIT) @(negedge clk100);
        check("pre_rst_tx_busy", {31'h0, uart_txd}, 0);
        reset    = 1'b0;
        uart_rxd = 1'b1;
        @(negedge clk100);
        check("rst_mid_txd", {31'h0, uart_txd}, 1);
        reset = 1'b1;
        check_read("rst_mid_rx_present", 8'h02, 8'h00);
        check_read("rst_mid_tx_full", 8'h03, 8'h00);
        check_read("rst_mid_err", 8'h04, 8'h00);
        check_read("rst_mid_rx_data", 8'h01, 8'h00);
        repeat (60) @(negedge clk100);
        txq.delete();
        io_write(8'h01, 8'h0F);
        wait_frames(1, 100);
        if (txq.size() > 0) begin
            check("post_rst_data", {24'h0, txq[0].data}, 32'h0F);
            check("post_rst_stop", {31'h0, txq[0].stop}, 1);
        end
        repeat (60) @(negedge clk100);
        check("post_rst_single_frame", txq.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
